// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch encodings, PC step and fetch sequencer states.
package cpu_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_J    = 2'b01;
  localparam logic [1:0] BR_BEQ  = 2'b10;
  localparam logic [1:0] BR_BNE  = 2'b11;

  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    MEM_WAIT = 3'd3,
    HALT     = 3'd4
  } fetch_state_t;

  function automatic logic branch_taken(input logic [1:0] br_type, input logic zero);
    logic taken;
    case (br_type)
      BR_J:    taken = 1'b1;
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = ~zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: sequential step plus optional signed word displacement,
// flagging any target outside instruction memory.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int IMEM_AW  = 10,
  parameter int OFFSET_W = 8
) (
  input  logic [PC_W-1:0]     pc,
  input  logic [1:0]          branch_type,
  input  logic [OFFSET_W-1:0] branch_offset,
  input  logic                alu_zero,
  output logic [PC_W-1:0]     next_pc,
  output logic                out_of_range
);

  logic signed [PC_W-1:0] offset_ext;
  logic        [PC_W-1:0] disp;

  always_comb begin
    offset_ext   = {{(PC_W-OFFSET_W){branch_offset[OFFSET_W-1]}}, branch_offset};
    disp         = branch_taken(branch_type, alu_zero) ? $unsigned(offset_ext <<< 2) : '0;
    // Wraps modulo 2^PC_W, so a target below zero lands in the high bits and halts.
    next_pc      = pc + PC_W'(PC_STEP) + disp;
    out_of_range = |next_pc[PC_W-1:IMEM_AW];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC and fetch sequencer: FETCH/EXEC/MEM_WAIT state machine with cache stalls,
// branch resolution and a sticky halt when the PC leaves instruction memory.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int IMEM_AW  = 10,
  parameter int OFFSET_W = 8,
  parameter int INSTR_W  = 32
) (
  input  logic                CLOCK,
  input  logic                RESET,
  output logic                icache_read,
  output logic [IMEM_AW-1:0]  icache_addr,
  input  logic [INSTR_W-1:0]  icache_rdata,
  input  logic                icache_busywait,
  input  logic                dcache_busywait,
  input  logic                mem_op,
  input  logic [1:0]          branch_type,
  input  logic [OFFSET_W-1:0] branch_offset,
  input  logic                alu_zero,
  output logic [INSTR_W-1:0]  instr,
  output logic                instr_valid,
  output logic [PC_W-1:0]     pc,
  output logic                halt
);

  fetch_state_t        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                icache_read_q, icache_read_d;
  logic                halt_q, halt_d;

  logic [1:0]          br_type_q;
  logic [OFFSET_W-1:0] br_off_q;
  logic                br_zero_q;

  logic [1:0]          calc_type;
  logic [OFFSET_W-1:0] calc_off;
  logic                calc_zero;
  logic [PC_W-1:0]     next_pc;
  logic                next_oor;
  logic                commit;

  // EXEC resolves from live decoder inputs; MEM_WAIT uses the copy taken on EXEC exit.
  always_comb begin
    if (state_q == EXEC) begin
      calc_type = branch_type;
      calc_off  = branch_offset;
      calc_zero = alu_zero;
    end else begin
      calc_type = br_type_q;
      calc_off  = br_off_q;
      calc_zero = br_zero_q;
    end
  end

  pc_next_calc #(
    .PC_W    (PC_W),
    .IMEM_AW (IMEM_AW),
    .OFFSET_W(OFFSET_W)
  ) u_pc_next_calc (
    .pc           (pc_q),
    .branch_type  (calc_type),
    .branch_offset(calc_off),
    .alu_zero     (calc_zero),
    .next_pc      (next_pc),
    .out_of_range (next_oor)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    icache_read_d = 1'b0;
    halt_d        = halt_q;
    commit        = 1'b0;
    case (state_q)
      IDLE: begin
        state_d       = FETCH;
        icache_read_d = 1'b1;
      end
      FETCH: begin
        if (icache_busywait) begin
          icache_read_d = 1'b1;
        end else begin
          instr_d       = icache_rdata;
          instr_valid_d = 1'b1;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        if (mem_op) state_d = MEM_WAIT;
        else        commit  = 1'b1;
      end
      MEM_WAIT: begin
        if (!dcache_busywait) commit = 1'b1;
      end
      HALT: begin
        halt_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Retire the instruction: advance the PC, then either fetch again or stop for good.
    if (commit) begin
      pc_d = next_pc;
      if (next_oor) begin
        halt_d  = 1'b1;
        state_d = HALT;
      end else begin
        state_d       = FETCH;
        icache_read_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      icache_read_q <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      icache_read_q <= icache_read_d;
      halt_q        <= halt_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (state_q == EXEC) begin
      br_type_q <= branch_type;
      br_off_q  <= branch_offset;
      br_zero_q <= alu_zero;
    end
  end

  assign icache_read = icache_read_q;
  assign icache_addr = pc_q[IMEM_AW-1:0];
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus a randomized instruction stream
// checked against a per-instruction arithmetic PC model.
module tb_pc_fetch_unit;

  localparam int PC_W     = 32;
  localparam int IMEM_AW  = 10;
  localparam int OFFSET_W = 8;
  localparam int INSTR_W  = 32;

  logic                CLOCK = 1'b0;
  logic                RESET = 1'b0;
  logic                icache_read;
  logic [IMEM_AW-1:0]  icache_addr;
  logic [INSTR_W-1:0]  icache_rdata;
  logic                icache_busywait = 1'b0;
  logic                dcache_busywait = 1'b0;
  logic                mem_op = 1'b0;
  logic [1:0]          branch_type = 2'b00;
  logic [OFFSET_W-1:0] branch_offset = '0;
  logic                alu_zero = 1'b0;
  logic [INSTR_W-1:0]  instr;
  logic                instr_valid;
  logic [PC_W-1:0]     pc;
  logic                halt;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [256];
  assign icache_rdata = imem[icache_addr[9:2]];

  always #5 CLOCK = ~CLOCK;

  pc_fetch_unit #(
    .PC_W(PC_W), .IMEM_AW(IMEM_AW), .OFFSET_W(OFFSET_W), .INSTR_W(INSTR_W)
  ) dut (
    .CLOCK          (CLOCK),
    .RESET          (RESET),
    .icache_read    (icache_read),
    .icache_addr    (icache_addr),
    .icache_rdata   (icache_rdata),
    .icache_busywait(icache_busywait),
    .dcache_busywait(dcache_busywait),
    .mem_op         (mem_op),
    .branch_type    (branch_type),
    .branch_offset  (branch_offset),
    .alu_zero       (alu_zero),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .halt           (halt)
  );

  // Reference: where one instruction sends the PC.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] bt,
                                             input logic [7:0] off, input bit az);
    bit     taken;
    longint delta;
    case (bt)
      2'd0:    taken = 1'b0;
      2'd1:    taken = 1'b1;
      2'd2:    taken = az;
      default: taken = !az;
    endcase
    delta = taken ? longint'($signed(off)) * 4 : 64'sd0;
    return 32'(longint'(cur) + 64'sd4 + delta);
  endfunction

  task automatic do_reset();
    RESET = 1'b0;
    icache_busywait = 1'b0; dcache_busywait = 1'b0;
    mem_op = 1'b0; branch_type = 2'b00; branch_offset = '0; alu_zero = 1'b0;
    repeat (2) @(negedge CLOCK);
    RESET = 1'b1;
  endtask

  task automatic wait_exec(input int prob, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (cycles < 100 && !ok) begin
      icache_busywait = ($urandom_range(0, 99) < prob);
      @(negedge CLOCK);
      cycles++;
      if (instr_valid === 1'b1) ok = 1'b1;
    end
    icache_busywait = 1'($urandom_range(0, 1));
  endtask

  // Called at the EXEC negedge; returns at the negedge after the instruction retires.
  task automatic issue(input bit mem, input logic [1:0] bt, input logic [7:0] off,
                       input bit az, input int d);
    mem_op = mem; branch_type = bt; branch_offset = off; alu_zero = az;
    dcache_busywait = 1'($urandom_range(0, 1));
    @(negedge CLOCK);
    if (mem) begin
      for (int j = 0; j <= d; j++) begin
        mem_op          = 1'($urandom_range(0, 1));
        branch_type     = 2'($urandom_range(0, 3));
        branch_offset   = 8'($urandom);
        alu_zero        = 1'($urandom_range(0, 1));
        icache_busywait = 1'($urandom_range(0, 1));
        dcache_busywait = (j < d);
        @(negedge CLOCK);
      end
    end
    mem_op = 1'b0; branch_type = 2'b00; branch_offset = '0; alu_zero = 1'b0;
    dcache_busywait = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) @(negedge CLOCK);
    checks++;
    if (icache_read !== 1'b0 || instr_valid !== 1'b0 || halt !== 1'b0 ||
        pc !== 32'd0 || instr !== 32'd0 || icache_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: read=%b valid=%b halt=%b pc=%h instr=%h addr=%h, required all zero",
               icache_read, instr_valid, halt, pc, instr, icache_addr);
    end
    RESET = 1'b1;
    @(negedge CLOCK);
    checks++;
    if (icache_read !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'd0) begin
      errors++;
      $display("FAIL idle_to_fetch: read=%b valid=%b pc=%h, required read=1 valid=0 pc=0",
               icache_read, instr_valid, pc);
    end
  endtask

  task automatic test_sequential();
    int cyc;
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_exec(0, cyc, ok);
      checks++;
      if (!ok || cyc != ((i == 0) ? 2 : 1)) begin
        errors++;
        $display("FAIL seq_cadence[%0d]: ok=%0d cycles=%0d, required %0d", i, ok, cyc, (i == 0) ? 2 : 1);
      end
      checks++;
      if (pc !== 32'(4 * i) || icache_addr !== 10'(4 * i) || instr !== imem[i] || icache_read !== 1'b0) begin
        errors++;
        $display("FAIL seq_exec[%0d]: pc=%h addr=%h instr=%h read=%b, required pc=%h instr=%h read=0",
                 i, pc, icache_addr, instr, icache_read, 4 * i, imem[i]);
      end
      issue(1'b0, 2'b00, 8'h00, 1'b0, 0);
      checks++;
      if (pc !== 32'(4 * (i + 1)) || icache_read !== 1'b1 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL seq_step[%0d]: pc=%h read=%b valid=%b, required pc=%h read=1 valid=0",
                 i, pc, icache_read, instr_valid, 4 * (i + 1));
      end
    end
  endtask

  task automatic test_icache_stall();
    int cyc;
    bit ok;
    logic [31:0] prev, last;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      wait_exec(0, cyc, ok);
      issue(1'b0, 2'b00, 8'h00, 1'b0, 0);
    end
    prev = imem[1];
    for (int k = 0; k < 5; k++) begin
      icache_busywait = 1'b1;
      imem[2] = $urandom;
      @(negedge CLOCK);
      checks++;
      if (instr_valid !== 1'b0 || icache_read !== 1'b1 || pc !== 32'd8 || instr !== prev) begin
        errors++;
        $display("FAIL icache_stall[%0d]: valid=%b read=%b pc=%h instr=%h, required valid=0 read=1 pc=8 instr=%h",
                 k, instr_valid, icache_read, pc, instr, prev);
      end
    end
    icache_busywait = 1'b0;
    last = $urandom;
    imem[2] = last;
    @(negedge CLOCK);
    checks++;
    if (instr_valid !== 1'b1 || instr !== last || icache_read !== 1'b0) begin
      errors++;
      $display("FAIL icache_release: valid=%b instr=%h read=%b, required valid=1 instr=%h read=0",
               instr_valid, instr, icache_read, last);
    end
  endtask

  task automatic test_branch();
    logic [1:0]  bts  [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
    bit          azs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps [4] = '{32'd12, 32'd20, 32'd20, 32'd12};
    int cyc;
    bit ok;
    for (int c = 0; c < 4; c++) begin
      do_reset();
      for (int i = 0; i < 4; i++) begin
        wait_exec(0, cyc, ok);
        issue(1'b0, 2'b00, 8'h00, 1'b0, 0);
      end
      wait_exec(0, cyc, ok);
      checks++;
      if (!ok || pc !== 32'd16) begin
        errors++;
        $display("FAIL branch_setup[%0d]: ok=%0d pc=%h, required pc=16", c, ok, pc);
      end
      issue(1'b0, bts[c], 8'hFE, azs[c], 0);
      wait_exec(0, cyc, ok);
      checks++;
      if (!ok || pc !== exps[c] || instr !== imem[exps[c][9:2]]) begin
        errors++;
        $display("FAIL branch[%0d] type=%b zero=%0d: pc=%h instr=%h, required pc=%h instr=%h",
                 c, bts[c], azs[c], pc, instr, exps[c], imem[exps[c][9:2]]);
      end
    end
  endtask

  task automatic test_mem_wait();
    int cyc;
    bit ok;
    do_reset();
    wait_exec(0, cyc, ok);
    issue(1'b0, 2'b00, 8'h00, 1'b0, 0);
    wait_exec(0, cyc, ok);
    mem_op = 1'b1; branch_type = 2'b00; branch_offset = 8'h00; alu_zero = 1'b0;
    dcache_busywait = 1'b1;
    @(negedge CLOCK);
    for (int k = 0; k <= 3; k++) begin
      checks++;
      if (pc !== 32'd4 || icache_read !== 1'b0 || instr_valid !== 1'b0 || halt !== 1'b0) begin
        errors++;
        $display("FAIL mem_wait_hold[%0d]: pc=%h read=%b valid=%b halt=%b, required pc=4 read=0 valid=0 halt=0",
                 k, pc, icache_read, instr_valid, halt);
      end
      mem_op = 1'b0; branch_type = 2'b01; branch_offset = 8'h10;
      icache_busywait = 1'b0;
      dcache_busywait = (k < 3);
      @(negedge CLOCK);
    end
    branch_type = 2'b00; branch_offset = 8'h00;
    checks++;
    if (pc !== 32'd8 || icache_read !== 1'b1 || halt !== 1'b0) begin
      errors++;
      $display("FAIL mem_wait_exit: pc=%h read=%b halt=%b, required pc=8 read=1 halt=0", pc, icache_read, halt);
    end
    wait_exec(0, cyc, ok);
    issue(1'b1, 2'b11, 8'h03, 1'b0, 2);
    checks++;
    if (pc !== 32'd24 || icache_read !== 1'b1) begin
      errors++;
      $display("FAIL mem_branch: pc=%h read=%b, required pc=24 read=1", pc, icache_read);
    end
  endtask

  task automatic test_halt();
    int cyc;
    bit ok;
    do_reset();
    wait_exec(0, cyc, ok);
    issue(1'b0, 2'b01, 8'hF0, 1'b0, 0);
    checks++;
    if (halt !== 1'b1 || pc !== 32'hFFFF_FFC4 || icache_read !== 1'b0 ||
        instr_valid !== 1'b0 || icache_addr !== 10'h3C4) begin
      errors++;
      $display("FAIL halt_entry: halt=%b pc=%h read=%b valid=%b addr=%h, required halt=1 pc=ffffffc4 read=0 valid=0 addr=3c4",
               halt, pc, icache_read, instr_valid, icache_addr);
    end
    for (int k = 0; k < 8; k++) begin
      icache_busywait = 1'($urandom_range(0, 1));
      dcache_busywait = 1'($urandom_range(0, 1));
      mem_op          = 1'($urandom_range(0, 1));
      branch_type     = 2'($urandom_range(0, 3));
      @(negedge CLOCK);
      checks++;
      if (halt !== 1'b1 || icache_read !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'hFFFF_FFC4) begin
        errors++;
        $display("FAIL halt_sticky[%0d]: halt=%b read=%b valid=%b pc=%h, required halt=1 read=0 valid=0 pc=ffffffc4",
                 k, halt, icache_read, instr_valid, pc);
      end
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (halt !== 1'b0 || pc !== 32'd0) begin
      errors++;
      $display("FAIL halt_reset: halt=%b pc=%h, required halt=0 pc=0", halt, pc);
    end
    @(negedge CLOCK);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    do_reset();
    wait_exec(0, cyc, ok);
    issue(1'b0, 2'b00, 8'h00, 1'b0, 0);
    wait_exec(0, cyc, ok);
    mem_op = 1'b1; dcache_busywait = 1'b1;
    @(negedge CLOCK);
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (pc !== 32'd0 || instr !== 32'd0 || instr_valid !== 1'b0 || icache_read !== 1'b0 || halt !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_memwait: pc=%h instr=%h valid=%b read=%b halt=%b, required all zero",
               pc, instr, instr_valid, icache_read, halt);
    end
    @(negedge CLOCK);
    do_reset();
    wait_exec(0, cyc, ok);
    checks++;
    if (!ok || pc !== 32'd0 || instr !== imem[0]) begin
      errors++;
      $display("FAIL restart_after_reset: ok=%0d pc=%h instr=%h, required pc=0 instr=%h", ok, pc, instr, imem[0]);
    end
    issue(1'b0, 2'b00, 8'h00, 1'b0, 0);
    icache_busywait = 1'b1;
    repeat (2) @(negedge CLOCK);
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (pc !== 32'd0 || icache_read !== 1'b0 || instr !== 32'd0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fetch: pc=%h read=%b instr=%h valid=%b, required all zero",
               pc, icache_read, instr, instr_valid);
    end
    @(negedge CLOCK);
  endtask

  task automatic test_random();
    int          cyc, d;
    bit          ok, mem, az, exp_halt;
    logic [1:0]  bt;
    logic [7:0]  off;
    logic [31:0] mpc, tgt;
    do_reset();
    mpc = 32'd0;
    for (int n = 0; n < 150; n++) begin
      wait_exec(40, cyc, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_timeout[%0d]: no instr_valid within %0d cycles", n, cyc);
        do_reset();
        mpc = 32'd0;
        continue;
      end
      checks++;
      if (pc !== mpc || instr !== imem[mpc[9:2]] || icache_addr !== mpc[9:0]) begin
        errors++;
        $display("FAIL rand_exec[%0d]: pc=%h instr=%h addr=%h, required pc=%h instr=%h",
                 n, pc, instr, icache_addr, mpc, imem[mpc[9:2]]);
      end
      mem = ($urandom_range(0, 2) == 0);
      bt  = 2'($urandom_range(0, 3));
      off = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 16) - 8);
      az  = 1'($urandom_range(0, 1));
      d   = mem ? int'($urandom_range(0, 3)) : 0;
      tgt = model_next(mpc, bt, off, az);
      exp_halt = (tgt > 32'd1020);
      issue(mem, bt, off, az, d);
      checks++;
      if (pc !== tgt || halt !== exp_halt || icache_read !== !exp_halt) begin
        errors++;
        $display("FAIL rand_retire[%0d] mem=%0d type=%b off=%h zero=%0d: pc=%h halt=%b read=%b, required pc=%h halt=%0d",
                 n, mem, bt, off, az, pc, halt, icache_read, tgt, exp_halt);
      end
      if (exp_halt) begin
        do_reset();
        mpc = 32'd0;
      end else begin
        mpc = tgt;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom | 32'h1;
    test_reset();
    test_sequential();
    test_icache_stall();
    test_branch();
    test_mem_wait();
    test_halt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
